// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - icache fetch controller with PC handshake, output register and redirect squash
//
// Purpose:
//   Issues icache reads for the PC, pulses pc_adv_o once per accepted word,
//   and holds the fetched word with its PC and PC+4 in one output register.
//   Decode takes the register with a valid/ready handshake. A redirect
//   squashes wrong-path work. A miss that is already in flight is drained
//   in S_DROP because the cache cannot abort it.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   halt_i       stop issuing new requests; an in-flight request completes
//   pcaddr_i     current PC from the program counter
//   redirect_i   taken branch/jump resolved; flush fetch
//   imem_ren_o   icache read enable
//   imemaddr_o   icache read address
//   ihit_i       icache hit; imemload_i is valid this cycle
//   imemload_i   icache read data
//   pc_adv_o     advance pulse to the program counter, one per accepted word
//   if_valid_o   output register holds a valid instruction
//   if_instr_o   fetched instruction
//   if_pc_o      address of if_instr_o
//   if_npc_o     if_pc_o + 4 (wraps modulo 2^ADDR_W)
//   id_ready_i   decode consumes the output when if_valid_o & id_ready_i
module instr_fetch_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               halt_i,
    input  logic [ADDR_W-1:0]  pcaddr_i,
    input  logic               redirect_i,
    output logic               imem_ren_o,
    output logic [ADDR_W-1:0]  imemaddr_o,
    input  logic               ihit_i,
    input  logic [INSTR_W-1:0] imemload_i,
    output logic               pc_adv_o,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic [ADDR_W-1:0]  if_npc_o,
    input  logic               id_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    // The PC steps on the same edge that starts a new request. For the first
    // cycle of that request, the address is taken live from pcaddr_i. It is
    // frozen into req_addr_q afterwards, so later PC changes cannot move an
    // outstanding read.
    logic               sel_pc_q, sel_pc_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [ADDR_W-1:0]  if_npc_q, if_npc_d;
    logic [ADDR_W-1:0]  cur_addr;
    logic               accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            sel_pc_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_npc_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            sel_pc_q   <= sel_pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_npc_q   <= if_npc_d;
        end
    end

    always_comb begin
        cur_addr   = sel_pc_q ? pcaddr_i : req_addr_q;
        state_d    = state_q;
        req_addr_d = req_addr_q;
        sel_pc_d   = 1'b0;
        imem_ren_o = 1'b0;
        imemaddr_o = req_addr_q;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!halt_i) begin
                    state_d  = S_FETCH;
                    sel_pc_d = 1'b1;
                end
            end
            S_FETCH: begin
                // Only request when the output register can take the word.
                imem_ren_o = !if_valid_q || id_ready_i;
                imemaddr_o = cur_addr;
                req_addr_d = cur_addr;
                accept     = imem_ren_o && ihit_i && !redirect_i && !rst_i;
                if (redirect_i) begin
                    if (ihit_i) begin
                        state_d  = halt_i ? S_IDLE : S_FETCH;
                        sel_pc_d = !halt_i;
                    end else begin
                        state_d  = S_DROP;
                    end
                end else if (accept) begin
                    state_d  = halt_i ? S_IDLE : S_FETCH;
                    sel_pc_d = !halt_i;
                end else if (halt_i && !imem_ren_o) begin
                    // Nothing is being requested, so halting loses nothing.
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                // Keep the wrong-path read alive until the cache answers, then discard it.
                imem_ren_o = 1'b1;
                if (ihit_i) begin
                    state_d  = halt_i ? S_IDLE : S_FETCH;
                    sel_pc_d = !halt_i;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: redirect beats refill, and refill beats consume, so
    // refill and consume on the same edge keep the register full.
    always_comb begin
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_npc_d   = if_npc_q;
        if (redirect_i) begin
            if_valid_d = 1'b0;
        end else if (accept) begin
            if_valid_d = 1'b1;
            if_instr_d = imemload_i;
            if_pc_d    = cur_addr;
            if_npc_d   = cur_addr + ADDR_W'(4);
        end else if (if_valid_q && id_ready_i) begin
            if_valid_d = 1'b0;
        end
    end

    assign pc_adv_o   = accept;
    assign if_valid_o = if_valid_q;
    assign if_instr_o = if_instr_q;
    assign if_pc_o    = if_pc_q;
    assign if_npc_o   = if_npc_q;

endmodule
